// File: rtl/nes_joypad_mux.sv
// nes_joypad_mux: per-port onboard/external controller front-end for the NES core.
// Optional feature: define JOYPAD_TURBO_EN to build the shared turbo counter and A/B gating.
module nes_joypad_mux #(
    parameter int NUM_PADS      = 2,
    parameter int DEBOUNCE_BITS = 16,
    parameter int TURBO_BITS    = 19
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [8*NUM_PADS-1:0] btn_raw,
    input  logic [NUM_PADS-1:0]   ext_sel,
    input  logic [2*NUM_PADS-1:0] turbo_sel,
    input  logic                  joy_strobe,
    input  logic [NUM_PADS-1:0]   joy_clock,
    input  logic [NUM_PADS-1:0]   joy_data_ext,
    output logic [NUM_PADS-1:0]   joy_data,
    output logic                  ext_strobe,
    output logic [NUM_PADS-1:0]   ext_clock
);
    localparam int NBTN = 8 * NUM_PADS;

    logic [NBTN-1:0]          btn_s1_q, btn_s2_q;
    logic [NUM_PADS-1:0]      ext_s1_q, ext_s2_q;
    logic [DEBOUNCE_BITS-1:0] dbc_q [NBTN];
    logic [DEBOUNCE_BITS-1:0] dbc_d [NBTN];
    logic [NBTN-1:0]          stable_q, stable_d;
    logic [NBTN-1:0]          eff_btn;
    logic [NUM_PADS-1:0]      last_clk_q;
    logic [7:0]               shreg_q [NUM_PADS];
    logic [7:0]               shreg_d [NUM_PADS];
    logic [NUM_PADS-1:0]      joy_data_q, joy_data_d;

    assign ext_strobe = joy_strobe;
    assign ext_clock  = joy_clock;
    assign joy_data   = joy_data_q;

    // A button only commits after staying different from stable for a full counter span.
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < NBTN; b++) begin
            dbc_d[b] = '0;
            if (btn_s2_q[b] != stable_q[b]) begin
                if (&dbc_q[b]) begin
                    stable_d[b] = btn_s2_q[b];
                end else begin
                    dbc_d[b] = dbc_q[b] + 1'b1;
                end
            end
        end
    end

`ifdef JOYPAD_TURBO_EN
    logic [TURBO_BITS-1:0] turbo_q, turbo_d;
    logic                  phase;

    assign turbo_d = turbo_q + 1'b1;
    assign phase   = turbo_q[TURBO_BITS-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            turbo_q <= '0;
        end else begin
            turbo_q <= turbo_d;
        end
    end

    always_comb begin
        eff_btn = stable_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            eff_btn[8*p]   = stable_q[8*p]   & (turbo_sel[2*p]   ? phase : 1'b1);
            eff_btn[8*p+1] = stable_q[8*p+1] & (turbo_sel[2*p+1] ? phase : 1'b1);
        end
    end
`else
    logic unused_turbo_sel;

    assign unused_turbo_sel = ^turbo_sel;
    assign eff_btn          = stable_q;
`endif

    // Strobe load takes priority over a falling read clock; ones shift in behind the data.
    always_comb begin
        joy_data_d = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            shreg_d[p] = shreg_q[p];
            if (joy_strobe) begin
                shreg_d[p] = eff_btn[8*p +: 8];
            end else if (last_clk_q[p] && !joy_clock[p]) begin
                shreg_d[p] = {1'b1, shreg_q[p][7:1]};
            end
            joy_data_d[p] = ext_sel[p] ? ~ext_s2_q[p] : shreg_d[p][0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            ext_s1_q   <= '0;
            ext_s2_q   <= '0;
            stable_q   <= '0;
            last_clk_q <= '0;
            joy_data_q <= '0;
            for (int b = 0; b < NBTN; b++) begin
                dbc_q[b] <= '0;
            end
            for (int p = 0; p < NUM_PADS; p++) begin
                shreg_q[p] <= '0;
            end
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            ext_s1_q   <= joy_data_ext;
            ext_s2_q   <= ext_s1_q;
            stable_q   <= stable_d;
            last_clk_q <= joy_clock;
            joy_data_q <= joy_data_d;
            for (int b = 0; b < NBTN; b++) begin
                dbc_q[b] <= dbc_d[b];
            end
            for (int p = 0; p < NUM_PADS; p++) begin
                shreg_q[p] <= shreg_d[p];
            end
        end
    end

endmodule
